// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b datapath types: memory-access FSM states and lane-index sizing.
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lc3b_mem_state;

    // Width of the byte-lane index for a data bus of data_w bits (at least 1).
    function automatic int unsigned lane_idx_w(input int unsigned data_w);
        return ((data_w / 8) > 1) ? $clog2(data_w / 8) : 1;
    endfunction

endpackage

// File: rtl/lc3b_lane_align.sv
// Byte-lane steering: replicate/enable lanes for stores, extract and zero-extend for loads.
module lc3b_lane_align #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LB     = 1
) (
    input  logic [LB-1:0]         lane,
    input  logic                  byte_mode,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W-1:0]     rdata_raw,
    output logic [DATA_W-1:0]     store_data,
    output logic [DATA_W/8-1:0]   byte_enable,
    output logic [DATA_W-1:0]     load_data
);
    localparam int unsigned NL = DATA_W / 8;

    // Word accesses pass straight through; byte accesses work on one lane.
    always_comb begin
        store_data  = wdata;
        byte_enable = '1;
        load_data   = rdata_raw;
        if (byte_mode) begin
            store_data  = {NL{wdata[7:0]}};
            byte_enable = NL'(1) << lane;
            load_data   = DATA_W'(rdata_raw[lane*8 +: 8]);
        end
    end

endmodule

// File: rtl/lc3b_mem_access.sv
// MAR/MDR memory-access unit: latches a request on start, runs the
// mem_read/mem_write handshake until mem_resp and returns load data.
// Optional abort-on-timeout is enabled with `define MEM_TIMEOUT_EN.
module lc3b_mem_access
    import lc3b_types::*;
#(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_write,
    input  logic                  byte_mode,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     rdata,
    output logic                  timeout_err,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_W/8-1:0]   mem_byte_enable,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_resp
);
    localparam int unsigned LB = lane_idx_w(DATA_W);
    localparam int unsigned NL = DATA_W / 8;

    lc3b_mem_state state_q, state_d;

    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] mdr_q;
    logic              byte_mode_q;
    logic [DATA_W-1:0] rdata_d;
    logic              busy_d, done_d, timeout_d;
    logic              mem_read_d, mem_write_d;
    logic [NL-1:0]     be_d;
    logic              latch;

    logic [LB-1:0]     lane;
    logic              lane_byte_mode;
    logic [DATA_W-1:0] store_data;
    logic [NL-1:0]     lane_be;
    logic [DATA_W-1:0] load_data;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // In IDLE the aligner steers the incoming request; afterwards the latched MAR.
    assign lane           = (state_q == IDLE) ? addr[LB-1:0] : mar_q[LB-1:0];
    assign lane_byte_mode = (state_q == IDLE) ? byte_mode : byte_mode_q;

    lc3b_lane_align #(
        .DATA_W (DATA_W),
        .LB     (LB)
    ) u_lane_align (
        .lane        (lane),
        .byte_mode   (lane_byte_mode),
        .wdata       (wdata),
        .rdata_raw   (mem_rdata),
        .store_data  (store_data),
        .byte_enable (lane_be),
        .load_data   (load_data)
    );

    // Memory sees a lane-aligned address; MAR and MDR are both registers.
    assign mem_address = {mar_q[ADDR_W-1:LB], LB'(0)};
    assign mem_wdata   = mdr_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        be_d        = '0;
        latch       = 1'b0;
        rdata_d     = rdata;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ACCESS;
                    busy_d      = 1'b1;
                    latch       = 1'b1;
                    mem_read_d  = ~is_write;
                    mem_write_d = is_write;
                    be_d        = is_write ? lane_be : '0;
`ifdef MEM_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            ACCESS: begin
                busy_d = 1'b1;
                if (mem_resp) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (mem_read) rdata_d = load_data;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    rdata_d   = '0;
                end
`endif
                else begin
                    mem_read_d  = mem_read;
                    mem_write_d = mem_write;
                    be_d        = mem_byte_enable;
`ifdef MEM_TIMEOUT_EN
                    cnt_d       = cnt_q + CW'(1);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            mar_q           <= '0;
            mdr_q           <= '0;
            byte_mode_q     <= 1'b0;
            rdata           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            timeout_err     <= 1'b0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            rdata           <= rdata_d;
            busy            <= busy_d;
            done            <= done_d;
            timeout_err     <= timeout_d;
            mem_read        <= mem_read_d;
            mem_write       <= mem_write_d;
            mem_byte_enable <= be_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q           <= cnt_d;
`endif
            if (latch) begin
                mar_q       <= addr;
                byte_mode_q <= byte_mode;
                if (is_write) mdr_q <= store_data;
            end
        end
    end

endmodule

// File: tb/tb_lc3b_mem_access.sv
// Scoreboard bench for lc3b_mem_access (16-bit data/address).
// Timeout scenarios run when compiled with `define MEM_TIMEOUT_EN.
module tb_lc3b_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_write;
    logic        byte_mode;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic [15:0] rdata;
    logic        timeout_err;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;

    int n_tests = 0;
    int n_fail  = 0;
    int n_dones = 0;
    int exp_dones = 0;
    logic [16:0] exp_q[$];

    lc3b_mem_access #(
        .DATA_W         (16),
        .ADDR_W         (16),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .is_write        (is_write),
        .byte_mode       (byte_mode),
        .addr            (addr),
        .wdata           (wdata),
        .busy            (busy),
        .done            (done),
        .rdata           (rdata),
        .timeout_err     (timeout_err),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected response.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_dones++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("done_rdata", 32'(rdata), 32'(e[15:0]));
                check("done_timeout_err", 32'(timeout_err), 32'(e[16]));
            end
        end
    end

    // One full transaction; dly = number of ACCESS cycles, mem_resp on the last one.
    task automatic do_access(input logic w, input logic bm, input logic [15:0] a,
                             input logic [15:0] wd, input int dly, input logic [15:0] rv,
                             input logic [15:0] ea, input logic [15:0] ewd,
                             input logic [1:0] ebe, input logic [15:0] er);
        @(negedge clk);
        start = 1'b1; is_write = w; byte_mode = bm; addr = a; wdata = wd;
        exp_q.push_back({1'b0, er});
        exp_dones++;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= dly; i++) begin
            if (i > 1) @(negedge clk);
            check("mem_address", 32'(mem_address), 32'(ea));
            check("mem_read", 32'(mem_read), 32'(!w));
            check("mem_write", 32'(mem_write), 32'(w));
            check("mem_byte_enable", 32'(mem_byte_enable), 32'(ebe));
            if (w) check("mem_wdata", 32'(mem_wdata), 32'(ewd));
            check("busy_access", 32'(busy), 32'd1);
            if (i == dly) begin
                mem_resp = 1'b1;
                mem_rdata = rv;
            end
        end
        @(negedge clk);
        mem_resp = 1'b0;
        mem_rdata = '0;
        check("req_dropped", 32'({mem_read, mem_write}), 32'd0);
        check("be_dropped", 32'(mem_byte_enable), 32'd0);
        check("busy_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_write = 1'b0; byte_mode = 1'b0;
        addr = '0; wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_req", 32'({mem_read, mem_write}), 32'd0);
        check("rst_address", 32'(mem_address), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);

        // Word load, 3 ACCESS cycles
        do_access(1'b0, 1'b0, 16'h3001, 16'h0000, 3, 16'hBEEF, 16'h3000, 16'h0, 2'b00, 16'hBEEF);
        // Byte loads, upper then lower lane
        do_access(1'b0, 1'b1, 16'h2003, 16'h0000, 2, 16'hA55A, 16'h2002, 16'h0, 2'b00, 16'h00A5);
        do_access(1'b0, 1'b1, 16'h2002, 16'h0000, 1, 16'hA55A, 16'h2002, 16'h0, 2'b00, 16'h005A);
        // Byte store: replicated data, one-hot lane, rdata kept
        do_access(1'b1, 1'b1, 16'h1001, 16'h1234, 2, 16'hFFFF, 16'h1000, 16'h3434, 2'b10, 16'h005A);
        // Word store with minimum latency
        do_access(1'b1, 1'b0, 16'h0ABC, 16'hCAFE, 1, 16'hFFFF, 16'h0ABC, 16'hCAFE, 2'b11, 16'h005A);

        // start while busy and mem_resp while idle are ignored
        @(negedge clk);
        start = 1'b1; is_write = 1'b0; byte_mode = 1'b0; addr = 16'h0100;
        exp_q.push_back({1'b0, 16'h7777});
        exp_dones++;
        @(negedge clk);
        addr = 16'h0F00; is_write = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_addr", 32'(mem_address), 32'h0100);
        check("busy_start_req", 32'({mem_read, mem_write}), 32'b10);
        mem_resp = 1'b1; mem_rdata = 16'h7777;
        @(negedge clk);
        mem_resp = 1'b0; mem_rdata = '0;
        @(negedge clk);
        mem_resp = 1'b1; mem_rdata = 16'h1111;
        @(negedge clk);
        mem_resp = 1'b0; mem_rdata = '0;
        check("idle_resp_done", 32'(done), 32'd0);
        check("idle_resp_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("idle_resp_req", 32'({mem_read, mem_write}), 32'd0);
        check("idle_resp_rdata", 32'(rdata), 32'h7777);

        // Reset two cycles into ACCESS
        @(negedge clk);
        start = 1'b1; is_write = 1'b0; byte_mode = 1'b0; addr = 16'h4000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_read", 32'(mem_read), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_rdata", 32'(rdata), 32'd0);
        mem_resp = 1'b1; mem_rdata = 16'h2222;
        @(negedge clk);
        mem_resp = 1'b0; mem_rdata = '0;
        check("rst_late_resp_done", 32'(done), 32'd0);
        @(negedge clk);
        check("rst_late_resp_done2", 32'(done), 32'd0);

`ifdef MEM_TIMEOUT_EN
        // No response: request held for 4 ACCESS cycles, then aborts
        @(negedge clk);
        start = 1'b1; is_write = 1'b0; byte_mode = 1'b0; addr = 16'h5000;
        exp_q.push_back({1'b1, 16'h0000});
        exp_dones++;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) @(negedge clk);
            check("to_req_held", 32'(mem_read), 32'd1);
        end
        @(negedge clk);
        check("to_req_dropped", 32'(mem_read), 32'd0);
        check("to_done", 32'(done), 32'd1);
        check("to_err", 32'(timeout_err), 32'd1);
        @(negedge clk);
        // Response on the limit cycle completes normally
        do_access(1'b0, 1'b0, 16'h6000, 16'h0000, 4, 16'h1111, 16'h6000, 16'h0, 2'b00, 16'h1111);
`endif

        repeat (3) @(negedge clk);
        check("dones_count", 32'(n_dones), 32'(exp_dones));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
